dest_resolver: RTL

- Parametrised next-generation destination calculator for the packet-filter datapath.
- Snoops the ingress header stream and assembles the 48-bit destination MAC from DATA_W-bit beats.
- Resolves the MAC to an egress port through a software-programmed match table and presents the result on a valid/ready handshake to the switch arbiter.
- Replaces fixed "low two MAC bits" port selection with real table lookup, default-port fallback and overrun detection.

---
 rtl/dest_resolver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dest_resolver.sv
// dest_resolver: assembles the 48-bit destination MAC from ingress beats and resolves it to an egress port.
// Optional build macro DEST_RESOLVER_FLOOD_EN: group-addressed MACs (I/G bit set) flood to all ports.
module dest_resolver #(
    parameter int  DATA_W       = 16,
    parameter int  N_PORTS      = 4,
    parameter int  TABLE_DEPTH  = 8,
    parameter int  DEFAULT_PORT = 0,
    localparam int MAC_BEATS    = 48 / DATA_W,
    localparam int PORT_W       = $clog2(N_PORTS),
    localparam int IDX_W        = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               tbl_wr_en,
    input  logic [IDX_W-1:0]   tbl_wr_idx,
    input  logic               tbl_wr_vld,
    input  logic [47:0]        tbl_wr_mac,
    input  logic [PORT_W-1:0]  tbl_wr_port,
    output logic               dest_valid,
    input  logic               dest_ready,
    output logic [PORT_W-1:0]  dest,
    output logic [N_PORTS-1:0] dest_mask,
    output logic               dest_hit,
    output logic               overrun
);
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAC_BEATS);

    typedef enum logic [1:0] {IDLE, CAPTURE, LOOKUP, PRESENT} state_t;
    localparam state_t FIRST_STATE = (MAC_BEATS == 1) ? LOOKUP : CAPTURE;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [47:0]        mac_q;
    logic               dest_valid_q;
    logic [PORT_W-1:0]  dest_q;
    logic [N_PORTS-1:0] dest_mask_q;
    logic               dest_hit_q;
    logic               overrun_q;

    logic               start;
    logic [47:0]        mac_shift;
    logic [CNT_W-1:0]   cnt_inc;
    logic               wr_ok;

    assign start   = in_valid && in_sof;
    assign cnt_inc = in_sof ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign wr_ok   = tbl_wr_en && ({1'b0, tbl_wr_idx} < (IDX_W+1)'(TABLE_DEPTH));

    // A single-beat MAC has no history to keep, so the shift degenerates to a load.
    generate
        if (MAC_BEATS == 1) begin : g_single
            assign mac_shift = in_data;
        end else begin : g_multi
            assign mac_shift = {mac_q[47-DATA_W:0], in_data};
        end
    endgenerate

    // Match table: one register set per entry; only the valid bit needs clearing on reset.
    logic [TABLE_DEPTH-1:0] match;
    logic [PORT_W-1:0]      ent_port [TABLE_DEPTH];

    for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_entry
        logic              vld_q;
        logic [47:0]       mac_e_q;
        logic [PORT_W-1:0] port_q;
        logic              sel;

        assign sel = wr_ok && (tbl_wr_idx == IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= 1'b0;
            end else if (sel) begin
                vld_q <= tbl_wr_vld;
            end
        end

        always_ff @(posedge clk) begin
            if (sel) begin
                mac_e_q <= tbl_wr_mac;
                port_q  <= tbl_wr_port;
            end
        end

        assign match[gi]    = vld_q && (mac_e_q == mac_q);
        assign ent_port[gi] = port_q;
    end

    logic [PORT_W-1:0]  port_d;
    logic               hit_d;
    logic [N_PORTS-1:0] mask_d;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit_d  = 1'b0;
        port_d = PORT_W'(DEFAULT_PORT);
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_d  = 1'b1;
                port_d = ent_port[i];
            end
        end
        mask_d = N_PORTS'(1) << port_d;
`ifdef DEST_RESOLVER_FLOOD_EN
        if (mac_q[40]) begin
            hit_d  = 1'b0;
            port_d = PORT_W'(DEFAULT_PORT);
            mask_d = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mac_q        <= '0;
            dest_valid_q <= 1'b0;
            dest_q       <= '0;
            dest_mask_q  <= '0;
            dest_hit_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mac_q   <= mac_shift;
                        cnt_q   <= CNT_W'(1);
                        state_q <= FIRST_STATE;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        mac_q <= mac_shift;
                        cnt_q <= cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_q <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    dest_q       <= port_d;
                    dest_mask_q  <= mask_d;
                    dest_hit_q   <= hit_d;
                    dest_valid_q <= 1'b1;
                    state_q      <= PRESENT;
                    if (start) begin
                        overrun_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (dest_ready) begin
                        dest_valid_q <= 1'b0;
                        state_q      <= IDLE;
                        if (start) begin
                            mac_q   <= mac_shift;
                            cnt_q   <= CNT_W'(1);
                            state_q <= FIRST_STATE;
                        end
                    end else if (start) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dest_valid = dest_valid_q;
    assign dest       = dest_q;
    assign dest_mask  = dest_mask_q;
    assign dest_hit   = dest_hit_q;
    assign overrun    = overrun_q;

endmodule
